// File: rtl/regfile_wb_ctrl.sv
// Write-back controller: round-robin arbitration onto the register file write port
// plus a per-register pending-write scoreboard. Define REGFILE_WB_BYPASS_EN for forwarding.

module regfile_wb_cnt #(
  parameter int PEND_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inc,
  input  logic              dec,
  output logic [PEND_W-1:0] cnt
);
  // inc and dec together leave the count unchanged; dec at zero holds zero
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                          cnt <= '0;
    else if (inc && !dec)              cnt <= cnt + PEND_W'(1);
    else if (dec && !inc && cnt != '0) cnt <= cnt - PEND_W'(1);
  end
endmodule

module regfile_wb_ctrl #(
  parameter int NUM_REQ = 3,
  parameter int PEND_W  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [5*NUM_REQ-1:0]  req_dest,
  input  logic [32*NUM_REQ-1:0] req_data,
  output logic                  rw_en,
  output logic [4:0]            rw_dest,
  output logic [31:0]           rw_data,
  input  logic                  issue_valid,
  input  logic [4:0]            issue_dest,
  output logic                  issue_ready,
  input  logic [4:0]            rs1,
  input  logic [4:0]            rs2,
  output logic                  hazard1,
  output logic                  hazard2,
  output logic                  fwd_hit1,
  output logic                  fwd_hit2,
  output logic [31:0]           fwd_data
);
  localparam int PTR_W = (NUM_REQ > 2) ? 2 : 1;
  localparam logic [PEND_W-1:0] CNT_MAX = '1;

  logic [NUM_REQ-1:0][4:0]  dest_v;
  logic [NUM_REQ-1:0][31:0] data_v;
  assign dest_v = req_dest;
  assign data_v = req_data;

  logic [PTR_W-1:0]   ptr;
  logic [PTR_W-1:0]   gidx;
  logic [NUM_REQ-1:0] grant;
  logic               any_vld;
  logic               hs;

  // first valid index at or after ptr, wrapping
  always_comb begin
    logic [PTR_W:0]   s;
    logic [PTR_W-1:0] idx;
    grant   = '0;
    gidx    = '0;
    any_vld = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      s = {1'b0, ptr} + (PTR_W+1)'(k);
      if (s >= (PTR_W+1)'(NUM_REQ)) s = s - (PTR_W+1)'(NUM_REQ);
      idx = s[PTR_W-1:0];
      if (!any_vld && req_valid[idx]) begin
        any_vld     = 1'b1;
        grant[idx]  = 1'b1;
        gidx        = idx;
      end
    end
  end

  assign req_ready = grant & {NUM_REQ{rst}};
  assign hs        = any_vld & rst;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)    ptr <= '0;
    else if (hs) ptr <= (gidx == PTR_W'(NUM_REQ-1)) ? '0 : gidx + PTR_W'(1);
  end

  // x0 writes are accepted but never reach the file
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rw_en   <= 1'b0;
      rw_dest <= '0;
      rw_data <= '0;
    end else if (hs) begin
      rw_en   <= (dest_v[gidx] != 5'd0);
      rw_dest <= dest_v[gidx];
      rw_data <= data_v[gidx];
    end else begin
      rw_en   <= 1'b0;
    end
  end

  logic [31:0][PEND_W-1:0] cnt;
  logic [31:1]             inc, dec;

  assign cnt[0] = '0;

  genvar r;
  generate
    for (r = 1; r < 32; r++) begin : g_cnt
      assign inc[r] = issue_valid & issue_ready & (issue_dest == 5'(r));
      assign dec[r] = rw_en & (rw_dest == 5'(r));
      regfile_wb_cnt #(.PEND_W(PEND_W)) u_cnt (
        .clk (clk),
        .rst (rst),
        .inc (inc[r]),
        .dec (dec[r]),
        .cnt (cnt[r])
      );
    end
  endgenerate

  assign issue_ready = (cnt[issue_dest] != CNT_MAX) |
                       (rw_en & (rw_dest == issue_dest) & (issue_dest != 5'd0));

`ifdef REGFILE_WB_BYPASS_EN
  // last outstanding write is on the port now: hand its data straight to decode
  assign fwd_hit1 = rw_en & (rs1 == rw_dest) & (rs1 != 5'd0) & (cnt[rs1] == PEND_W'(1));
  assign fwd_hit2 = rw_en & (rs2 == rw_dest) & (rs2 != 5'd0) & (cnt[rs2] == PEND_W'(1));
  assign fwd_data = (fwd_hit1 | fwd_hit2) ? rw_data : '0;
  assign hazard1  = (cnt[rs1] != '0) & ~fwd_hit1;
  assign hazard2  = (cnt[rs2] != '0) & ~fwd_hit2;
`else
  assign fwd_hit1 = 1'b0;
  assign fwd_hit2 = 1'b0;
  assign fwd_data = '0;
  assign hazard1  = (cnt[rs1] != '0);
  assign hazard2  = (cnt[rs2] != '0);
`endif

  a_no_underflow: assert property (@(posedge clk) disable iff (!rst)
    rw_en |-> (cnt[rw_dest] != '0));
  a_one_grant: assert property (@(posedge clk) disable iff (!rst)
    $onehot0(req_ready));

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Directed bench for regfile_wb_ctrl: write-port scoreboard plus inline checks
// of grants, scoreboard hazards, issue back-pressure and optional forwarding.

module tb_regfile_wb_ctrl;
  localparam int NR = 3;

`ifdef REGFILE_WB_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic [NR-1:0]   req_valid;
  logic [NR-1:0]   req_ready;
  logic [5*NR-1:0] req_dest;
  logic [32*NR-1:0] req_data;
  logic            rw_en;
  logic [4:0]      rw_dest;
  logic [31:0]     rw_data;
  logic            issue_valid;
  logic [4:0]      issue_dest;
  logic            issue_ready;
  logic [4:0]      rs1, rs2;
  logic            hazard1, hazard2, fwd_hit1, fwd_hit2;
  logic [31:0]     fwd_data;

  regfile_wb_ctrl #(.NUM_REQ(NR), .PEND_W(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_dest(req_dest), .req_data(req_data),
    .rw_en(rw_en), .rw_dest(rw_dest), .rw_data(rw_data),
    .issue_valid(issue_valid), .issue_dest(issue_dest), .issue_ready(issue_ready),
    .rs1(rs1), .rs2(rs2),
    .hazard1(hazard1), .hazard2(hazard2),
    .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2), .fwd_data(fwd_data)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [4:0] d; logic [31:0] v; } wr_t;
  wr_t exp_q[$];
  int  n_pass = 0, n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h required %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_req(input int i, input logic [4:0] d, input logic [31:0] v);
    req_valid[i]         = 1'b1;
    req_dest[i*5 +: 5]   = d;
    req_data[i*32 +: 32] = v;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    // write-port monitor: every rw_en cycle must match the next expected write
    fork
      forever begin
        @(negedge clk);
        if (rst && rw_en) begin
          if (exp_q.size() == 0) begin
            n_total++;
            $display("FAIL unexpected_write: got dest %0d data %0h, required no write", rw_dest, rw_data);
          end else begin
            wr_t e;
            e = exp_q.pop_front();
            chk("wb_dest", 32'(rw_dest), 32'(e.d));
            chk("wb_data", rw_data, e.v);
          end
        end
      end
    join_none

    rst = 1'b0; req_valid = '1; req_dest = '0; req_data = '0;
    issue_valid = 1'b0; issue_dest = '0; rs1 = '0; rs2 = '0;
    #3;
    chk("rst_rw_en", 32'(rw_en), 0);
    chk("rst_rw_dest", 32'(rw_dest), 0);
    chk("rst_rw_data", rw_data, 0);
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_issue_ready", 32'(issue_ready), 1);
    chk("rst_fwd_data", fwd_data, 0);
    req_valid = '0;
    @(negedge clk); rst = 1'b1;

    // single write to x5 through ALU
    tick();
    issue_valid = 1'b1; issue_dest = 5'd5; rs1 = 5'd5; #1;
    chk("sw_issue_ready", 32'(issue_ready), 1);
    chk("sw_haz_pre", 32'(hazard1), 0);
    tick();
    issue_valid = 1'b0; #1;
    chk("sw_haz_issued", 32'(hazard1), 1);
    set_req(0, 5'd5, 32'hDEADBEEF); exp_q.push_back({5'd5, 32'hDEADBEEF}); #1;
    chk("sw_grant", 32'(req_ready), 32'b001);
    tick();
    req_valid = '0; #1;
    chk("sw_rw_en", 32'(rw_en), 1);
    chk("sw_haz_wb", 32'(hazard1), BYP ? 0 : 1);
    chk("sw_fwd_hit1", 32'(fwd_hit1), BYP ? 1 : 0);
    tick(); #1;
    chk("sw_haz_post", 32'(hazard1), 0);
    chk("sw_rw_en_off", 32'(rw_en), 0);

    // x0 through LSU: accepted, never written
    tick();
    set_req(1, 5'd0, 32'h0000BAD0); rs1 = 5'd0; #1;
    chk("x0_grant", 32'(req_ready), 32'b010);
    chk("x0_haz", 32'(hazard1), 0);
    tick();
    req_valid = '0; #1;
    chk("x0_rw_en", 32'(rw_en), 0);

    // saturate x7 then drain / overlap
    tick();
    issue_valid = 1'b1; issue_dest = 5'd7; rs2 = 5'd7;
    tick(); tick(); tick();
    issue_valid = 1'b0; #1;
    chk("sat_ready", 32'(issue_ready), 0);
    chk("sat_haz2", 32'(hazard2), 1);
    set_req(0, 5'd7, 32'h00000077); exp_q.push_back({5'd7, 32'h00000077});
    tick();
    req_valid = '0; #1;
    chk("sat_ready_dec", 32'(issue_ready), 1);
    tick(); #1;
    chk("sat_ready_cnt2", 32'(issue_ready), 1);
    set_req(0, 5'd7, 32'h0000007A); exp_q.push_back({5'd7, 32'h0000007A});
    tick();
    req_valid = '0; issue_valid = 1'b1; #1;
    chk("sim_ready", 32'(issue_ready), 1);
    tick(); #1;
    chk("sim_cnt_held", 32'(issue_ready), 1);
    tick();
    issue_valid = 1'b0; #1;
    chk("sim_resat", 32'(issue_ready), 0);

    // forwarding through CSR to x9
    tick();
    issue_valid = 1'b1; issue_dest = 5'd9; rs2 = 5'd9;
    tick();
    issue_valid = 1'b0;
    set_req(2, 5'd9, 32'h12345678); exp_q.push_back({5'd9, 32'h12345678}); #1;
    chk("byp_grant", 32'(req_ready), 32'b100);
    chk("byp_haz_pre", 32'(hazard2), 1);
    tick();
    req_valid = '0; #1;
    chk("byp_hit2", 32'(fwd_hit2), BYP ? 1 : 0);
    chk("byp_data", fwd_data, BYP ? 32'h12345678 : 32'h0);
    chk("byp_haz2", 32'(hazard2), BYP ? 0 : 1);
    chk("byp_hit1", 32'(fwd_hit1), 0);
    tick(); #1;
    chk("byp_haz_post", 32'(hazard2), 0);
    chk("byp_hit_post", 32'(fwd_hit2), 0);

    // reset clears scoreboard and pointer
    tick();
    rst = 1'b0; #1; rst = 1'b1; rs2 = 5'd7; #1;
    chk("rst_clr_x7", 32'(hazard2), 0);

    // round robin, all three valid
    tick();
    issue_valid = 1'b1; issue_dest = 5'd1;
    tick(); tick();
    issue_dest = 5'd2;
    tick();
    issue_dest = 5'd3;
    tick();
    issue_valid = 1'b0;
    set_req(0, 5'd1, 32'hA1); set_req(1, 5'd2, 32'hA2); set_req(2, 5'd3, 32'hA3);
    exp_q.push_back({5'd1, 32'hA1}); exp_q.push_back({5'd2, 32'hA2});
    exp_q.push_back({5'd3, 32'hA3}); exp_q.push_back({5'd1, 32'hA1});
    #1; chk("rr_g0", 32'(req_ready), 32'b001);
    tick(); chk("rr_g1", 32'(req_ready), 32'b010); chk("rr_en1", 32'(rw_en), 1);
    tick(); chk("rr_g2", 32'(req_ready), 32'b100); chk("rr_en2", 32'(rw_en), 1);
    tick(); chk("rr_g3", 32'(req_ready), 32'b001); chk("rr_en3", 32'(rw_en), 1);
    tick(); chk("rr_en4", 32'(rw_en), 1);

    // reset mid-write
    @(negedge clk); #1;
    rst = 1'b0; #1;
    chk("mid_rw_en", 32'(rw_en), 0);
    chk("mid_rw_dest", 32'(rw_dest), 0);
    chk("mid_rw_data", rw_data, 0);
    chk("mid_req_ready", 32'(req_ready), 0);
    req_valid = '0;
    @(negedge clk); rst = 1'b1;
    tick();
    rs1 = 5'd1; rs2 = 5'd3; #1;
    chk("post_haz1", 32'(hazard1), 0);
    chk("post_haz2", 32'(hazard2), 0);

    tick(); tick();
    chk("sb_drained", 32'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
